vram_arbiter: RTL

Shares one single-port synchronous video RAM between two requesters in the pix_clk domain. The display pixel fetcher, driven by the VGA timing generator, has absolute priority. A CPU/drawing-engine write port is buffered through a small FIFO. Writes drain only in idle slots, optionally restricted to blanking intervals so scan-out never contends with updates.

---
 rtl/vram_arbiter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Single-port video RAM arbiter: display reads take absolute priority; CPU writes are
// buffered in a small FIFO and drain in idle slots (optionally only during blanking).
module vram_arbiter #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned WFIFO_DEPTH   = 4,
  parameter bit          WR_BLANK_ONLY = 1'b1
) (
  input  logic                           pix_clk,
  input  logic                           reset,
  input  logic                           in_display,
  input  logic                           disp_req,
  input  logic [ADDR_W-1:0]              disp_addr,
  output logic [DATA_W-1:0]              disp_data,
  output logic                           disp_valid,
  input  logic                           cpu_wr_valid,
  input  logic [ADDR_W-1:0]              cpu_wr_addr,
  input  logic [DATA_W-1:0]              cpu_wr_data,
  output logic                           cpu_wr_ready,
  output logic [$clog2(WFIFO_DEPTH):0]   fifo_level,
  output logic                           ram_en,
  output logic                           ram_we,
  output logic [ADDR_W-1:0]              ram_addr,
  output logic [DATA_W-1:0]              ram_wdata,
  input  logic [DATA_W-1:0]              ram_rdata
);

  localparam int unsigned PtrW = $clog2(WFIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;

  typedef enum logic [1:0] {SlotIdle, SlotDisp, SlotWr} slot_e;

  logic [ADDR_W+DATA_W-1:0] fifo_mem_q [WFIFO_DEPTH];
  logic [PtrW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]          count_q, count_d;

  logic                     ram_en_q, ram_en_d;
  logic                     ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]        ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]        ram_wdata_q, ram_wdata_d;
  logic                     disp_valid_q, disp_valid_d;

  logic                     full, empty, push, pop, wr_ok;
  logic [ADDR_W-1:0]        head_addr;
  logic [DATA_W-1:0]        head_data;
  slot_e                    slot;

  assign full   = (count_q == LvlW'(WFIFO_DEPTH));
  assign empty  = (count_q == '0);
  assign push   = cpu_wr_valid && !full;
  assign wr_ok  = !empty && (!WR_BLANK_ONLY || !in_display);
  assign {head_addr, head_data} = fifo_mem_q[rd_ptr_q];

  always_comb begin
    slot        = SlotIdle;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if (disp_req) begin
      slot = SlotDisp;
    end else if (wr_ok) begin
      slot = SlotWr;
    end
    case (slot)
      SlotDisp: begin
        ram_en_d   = 1'b1;
        ram_addr_d = disp_addr;
      end
      SlotWr: begin
        ram_en_d    = 1'b1;
        ram_we_d    = 1'b1;
        ram_addr_d  = head_addr;
        ram_wdata_d = head_data;
      end
      default: ;
    endcase
  end

  assign pop          = (slot == SlotWr);
  assign disp_valid_d = ram_en_q && !ram_we_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    count_d  = count_q + LvlW'(push) - LvlW'(pop);
  end

  // Storage needs no reset; clearing the pointers and count discards queued writes.
  always_ff @(posedge pix_clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {cpu_wr_addr, cpu_wr_data};
    end
  end

  always_ff @(posedge pix_clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      disp_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      disp_valid_q <= disp_valid_d;
    end
  end

  assign cpu_wr_ready = !full;
  assign fifo_level   = count_q;
  assign ram_en       = ram_en_q;
  assign ram_we       = ram_we_q;
  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign disp_valid   = disp_valid_q;
  assign disp_data    = ram_rdata;

endmodule
